// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple nibble per clock, LSB first,
// with the inter-nibble carry registered so the critical path is one 4-bit stage.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0] a_nib, b_nib, s4;
    logic [4:0] rc;
    logic       c4;

    // Pick the operand nibbles addressed by the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // 4-bit ripple-carry stage fed by the registered carry.
    always_comb begin
        rc    = '0;
        s4    = '0;
        rc[0] = carry_q;
        for (int unsigned j = 0; j < 4; j++) begin
            s4[j]   = a_nib[j] ^ b_nib[j] ^ rc[j];
            rc[j+1] = (a_nib[j] & b_nib[j]) | (rc[j] & (a_nib[j] ^ b_nib[j]));
        end
        c4 = rc[4];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = s4;
                    end
                end
                carry_d = c4;
                if (idx_q == IDX_W'(NIB - 1)) begin
                    cout_d  = c4;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 16-bit instance checked through
// a result queue, plus a 4-bit instance for the single-nibble case.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cin;
    logic [15:0] a, b;
    logic        busy, done, cout;
    logic [15:0] sum;

    logic        start4, cin4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, cout4;
    logic [3:0]  sum4;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ndone  = 0;
    int prev_done_cyc = -1;
    int last_done_cyc = -1;

    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Pop the oldest expectation on every done pulse.
    always @(negedge clk) begin
        logic [16:0] e;
        if (done) begin
            ndone++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e[15:0]));
                check("cout", 32'(cout), 32'(e[16]));
            end
        end
    end

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 30);
        if (!done) check("done_timeout", 32'(0), 32'(1));
    endtask

    // Full transaction with cycle-exact busy/done timing; values via scoreboard.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] e;
        e     = model(x, y, c);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        check("busy_first", 32'(busy), 32'(1));
        check("sum_cleared", 32'(sum), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_run", 32'({busy, done}), 32'(2'b10));
        end
        @(negedge clk);
        check("done_latency", 32'({busy, done}), 32'(2'b01));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'(0));
        check("sum_held", 32'({cout, sum}), 32'(e));
    endtask

    initial begin
        int nd;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({busy, done, cout, sum}), 32'(0));
        check("rst_outputs4", 32'({busy4, done4, cout4, sum4}), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1);

        // start and operand changes during RUN must be ignored
        nd = ndone;
        a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h8000, 16'h8000, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'h0000; b = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        check("one_done_pulse", 32'(ndone - nd), 32'(1));

        // reset in the second RUN cycle abandons the operation
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("partial_before_rst", 32'(sum), 32'(16'h0003));
        rst = 1'b1;
        exp_q.delete();
        nd = ndone;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst", 32'({busy, done, cout, sum}), 32'(0));
        repeat (8) @(negedge clk);
        check("no_done_after_rst", 32'(ndone - nd), 32'(0));
        run_op(16'hA5A5, 16'h5A5A, 1'b1);

        // back-to-back accept on the DONE edge
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h1234, 16'h1111, 1'b0));
        wait_done();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0;
        exp_q.push_back(model(16'h00FF, 16'h0001, 1'b0));
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'(1));
        wait_done();
        @(negedge clk);
        check("b2b_gap", 32'(last_done_cyc - prev_done_cyc), 32'(5));
        check("b2b_sum", 32'({cout, sum}), 32'(17'h00100));

        for (int i = 0; i < 4; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom));
        end
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        // WIDTH=4: single RUN cycle
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("w4_busy", 32'({busy4, done4}), 32'(2'b10));
        @(negedge clk);
        check("w4_done", 32'({busy4, done4}), 32'(2'b01));
        check("w4_result", 32'({cout4, sum4}), 32'(5'h11));
        a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("w4_result2", 32'({done4, cout4, sum4}), 32'(6'h28));
        @(negedge clk);
        check("w4_held", 32'({done4, cout4, sum4}), 32'(6'h08));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that adds one 4-bit nibble per clock through an internal 4-bit ripple-carry add stage, LSB nibble first.
- The controller sequences operands into the nibble stage and collects its sum and carry outputs.
- Carry is registered between nibbles, so the wide add costs no more combinational depth than a single 4-bit ripple stage.
- Sits between an operand producer (start/operand handshake) and a result consumer (done pulse, held result).

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- Derived, not overridable: NIB = WIDTH/4, the nibble count. Nibble index counter is clog2(NIB) bits, minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- start  input  1  request an add; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- cin  input  1  carry-in to nibble 0; sampled only on the accepting edge.
- busy  output  1  high while nibbles are being processed (state RUN).
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the top nibble.

Behaviour:
- Reset (rst=1 at a clk edge) forces state=IDLE, busy=0, done=0, sum=0, cout=0, nibble index=0, internal carry=0, and clears the operand latches.
- Reset has priority over every other input, including mid-RUN: any in-flight operation is abandoned and no done pulse is produced.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept: start=1 at an edge while in IDLE or DONE. On that edge:
  - latch a, b, cin;
  - clear sum to 0 and cout to 0;
  - set index=0 and internal carry=cin;
  - go to RUN.
- start=1 while in RUN is ignored, with no side effects. Changes to a, b, cin after acceptance are ignored.
- RUN, one nibble per edge, for nibble i = index:
  - {c4, s4} = A[4i+3:4i] + B[4i+3:4i] + carry, using 4-bit ripple arithmetic;
  - sum[4i+3:4i] <= s4 and carry <= c4;
  - index increments.
  - On the edge processing nibble NIB-1: cout <= c4, and the state goes to DONE.
- Latency: if start is accepted at edge k, nibbles are processed at edges k+1 … k+NIB, and done is high during the cycle following edge k+NIB. Accept-to-done is NIB+1 edges; for WIDTH=16 that is 5.
- DONE lasts one cycle, then goes to IDLE unless start=1 (back-to-back accept, which goes directly to RUN).
- sum and cout hold their final values through DONE and IDLE until the next accept or reset.
- sum is partial, and not valid, while busy=1.
- Arithmetic is modulo 2^WIDTH; carry-out is reported only on cout; there is no overflow flag.
- The index never exceeds NIB-1; no wrap beyond the operand width.
- WIDTH=4: a single RUN cycle; behaviour is otherwise identical.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start pulsed at edge k -> busy=1 for 4 cycles; done=1 in the cycle after edge k+4; sum=0x5555, cout=0; values held afterward.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through every nibble; sum=0x0000, cout=1. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- During RUN: pulse start and change a/b to 0x0000 -> ignored; result equals the originally latched operands (0x8000+0x8000 -> sum=0x0000, cout=1); exactly one done pulse.
- Assert rst on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows. A new start after reset completes normally.
- Back-to-back: start held high through the DONE cycle with new operands 0x00FF+0x0001 -> second op accepted on the DONE edge; sum=0x0100, cout=0; done pulses 5 edges apart.
- WIDTH=4: a=0x9, b=0x8, cin=0 -> done after 2 edges; sum=0x1, cout=1.
